// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Multicycle RV32I control FSM. Sequences one instruction through
//            FETCH, DECODE, EXECUTE, MEM and WRITEBACK, driving memory
//            handshakes, enables and datapath mux selects.
// Options  : CTRL_ILLEGAL_TRAP_EN - when defined, illegal opcodes enter a
//            sticky TRAP state; otherwise they retire as NOPs.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal_instr,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_fence  = 7'b0001111;
  localparam logic [6:0] c_op_system = 7'b1110011;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] w_opcode;
  logic       w_illegal_flag;

  logic       w_imem_req;
  logic       w_ir_we;
  logic       w_pc_we;
  logic [1:0] w_pc_sel;
  logic       w_alu_src_a;
  logic       w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_dmem_req;
  logic       w_dmem_we;
  logic       w_reg_we;
  logic [1:0] w_wb_sel;

  // Only the opcode field steers control; the rest of the IR feeds the datapath.
  logic       w_unused_instr;
  assign w_opcode       = instr[6:0];
  assign w_unused_instr = ^instr[31:7];

  // State register; reset returns to the configured entry state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      r_state <= w_next;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic w_legal;
  logic r_illegal;

  // Legal means one of the eleven base opcodes (all of which end in 2'b11).
  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      c_op_op, c_op_imm, c_op_load, c_op_store, c_op_branch, c_op_lui,
      c_op_auipc, c_op_jal, c_op_jalr, c_op_fence, c_op_system: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Sticky illegal flag, set on the edge that enters TRAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else if (w_next == S_TRAP) begin
      r_illegal <= 1'b1;
    end
  end

  assign w_illegal_flag = r_illegal | (r_state == S_TRAP);
`else
  assign w_illegal_flag = 1'b0;
`endif

  // Next-state and per-state control outputs; every output defaults to 0.
  always_comb begin
    w_next      = r_state;
    w_imem_req  = 1'b0;
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_sel    = 2'd0;
    w_alu_src_a = 1'b0;
    w_alu_src_b = 1'b0;
    w_alu_op    = 2'd0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_reg_we    = 1'b0;
    w_wb_sel    = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = S_EXECUTE;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!w_legal) begin
          w_next = S_TRAP;
        end
`endif
      end
      S_EXECUTE: begin
        case (w_opcode)
          c_op_op: begin
            w_alu_op = 2'd2;
            w_next   = S_WRITEBACK;
          end
          c_op_imm: begin
            w_alu_op    = 2'd2;
            w_alu_src_b = 1'b1;
            w_next      = S_WRITEBACK;
          end
          c_op_load, c_op_store: begin
            w_alu_src_b = 1'b1;
            w_next      = S_MEM;
          end
          c_op_branch: begin
            w_alu_op = 2'd1;
            w_pc_we  = 1'b1;
            w_pc_sel = branch_taken ? 2'd1 : 2'd0;
            w_next   = S_FETCH;
          end
          c_op_lui: begin
            w_alu_op    = 2'd3;
            w_alu_src_b = 1'b1;
            w_next      = S_WRITEBACK;
          end
          c_op_auipc: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 1'b1;
            w_next      = S_WRITEBACK;
          end
          c_op_jal: begin
            w_next = S_WRITEBACK;
          end
          c_op_jalr: begin
            w_alu_src_b = 1'b1;
            w_next      = S_WRITEBACK;
          end
          default: begin
            // FENCE, SYSTEM and untrapped illegal opcodes retire as NOPs.
            w_pc_we = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (w_opcode == c_op_store);
        if (dmem_ready) begin
          if (w_opcode == c_op_store) begin
            w_pc_we = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next  = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        w_reg_we = 1'b1;
        w_pc_we  = 1'b1;
        case (w_opcode)
          c_op_load: w_wb_sel = 2'd1;
          c_op_jal: begin
            w_wb_sel = 2'd2;
            w_pc_sel = 2'd1;
          end
          c_op_jalr: begin
            w_wb_sel = 2'd2;
            w_pc_sel = 2'd2;
          end
          default: w_wb_sel = 2'd0;
        endcase
        w_next = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Reset masks every output combinationally, including in-flight requests.
  assign imem_req      = w_imem_req  & ~rst;
  assign ir_we         = w_ir_we     & ~rst;
  assign pc_we         = w_pc_we     & ~rst;
  assign pc_sel        = rst ? 2'd0 : w_pc_sel;
  assign alu_src_a     = w_alu_src_a & ~rst;
  assign alu_src_b     = w_alu_src_b & ~rst;
  assign alu_op        = rst ? 2'd0 : w_alu_op;
  assign dmem_req      = w_dmem_req  & ~rst;
  assign dmem_we       = w_dmem_we   & ~rst;
  assign reg_we        = w_reg_we    & ~rst;
  assign wb_sel        = rst ? 2'd0 : w_wb_sel;
  assign illegal_instr = w_illegal_flag & ~rst;
  assign state         = rst ? 3'd0 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Purpose  : Self-checking bench for multicycle_control_unit. Each instruction
//            is summarised by a per-opcode reference (latency, final selects,
//            memory behaviour) and the observed cycle trace is checked
//            against it. Honours CTRL_ILLEGAL_TRAP_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, branch_taken;
  logic        imem_req, ir_we, pc_we, alu_src_a, alu_src_b;
  logic        dmem_req, dmem_we, reg_we, illegal_instr;
  logic [1:0]  pc_sel, alu_op, wb_sel;
  logic [2:0]  state;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .illegal_instr(illegal_instr), .state(state)
  );

  // Per-instruction summary of what the control unit must do.
  typedef struct {
    int         lat;     // cycles with zero-wait memory
    logic       memop;
    logic       store;
    logic       writes;  // register write expected
    logic [1:0] wb;
    logic [1:0] psel;    // pc_sel on the single pc_we cycle
    logic [1:0] aop;     // ALU controls during EXECUTE
    logic       asa;
    logic       asb;
  } exp_t;

  function automatic exp_t model(input logic [6:0] op, input logic bt);
    exp_t e;
    e.lat = 4; e.memop = 0; e.store = 0; e.writes = 0; e.wb = 0;
    e.psel = 0; e.aop = 0; e.asa = 0; e.asb = 0;
    case (op)
      7'b0110011: e.aop = 2;
      7'b0010011: begin e.aop = 2; e.asb = 1; end
      7'b0000011: begin e.lat = 5; e.memop = 1; e.asb = 1; e.wb = 1; end
      7'b0100011: begin e.memop = 1; e.store = 1; e.asb = 1; end
      7'b1100011: begin e.lat = 3; e.aop = 1; e.psel = bt ? 2'd1 : 2'd0; end
      7'b0110111: begin e.aop = 3; e.asb = 1; end
      7'b0010111: begin e.asa = 1; e.asb = 1; end
      7'b1101111: begin e.wb = 2; e.psel = 1; end
      7'b1100111: begin e.asb = 1; e.wb = 2; e.psel = 2; end
      default:    e.lat = 3;  // FENCE, SYSTEM, untrapped illegal
    endcase
    e.writes = (e.lat >= 4) && !e.store;
    return e;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111, 7'b1110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs one instruction from its first FETCH cycle up to its pc_we cycle.
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                           input logic bt, input string name);
    exp_t e;
    int f, total, mstart, mready;
    int n_imem, n_dmem, n_dwe, n_pcwe, n_regwe, pcwe_cyc, irwe_cyc;
    logic [1:0] psel_seen, wb_seen, aop_seen;
    logic asa_seen, asb_seen;
    logic [2:0] dec_state;
    logic done;
    e = model(ins[6:0], bt);
    f = iw + 1;
    total = e.lat + iw + (e.memop ? dw : 0);
    mstart = f + 3;
    mready = f + 3 + dw;
    n_imem = 0; n_dmem = 0; n_dwe = 0; n_pcwe = 0; n_regwe = 0;
    pcwe_cyc = 0; irwe_cyc = 0; psel_seen = 0; wb_seen = 0;
    aop_seen = 0; asa_seen = 0; asb_seen = 0; dec_state = 3'd7;
    instr = ins; branch_taken = bt;
    for (int c = 1; c <= 60; c++) begin
      if (c < f)       imem_ready = 1'b0;
      else if (c == f) imem_ready = 1'b1;
      else             imem_ready = 1'($urandom % 2);
      if (e.memop && c >= mstart && c <= mready) dmem_ready = (c == mready);
      else dmem_ready = 1'($urandom % 2);
      @(negedge clk);
      if (imem_req) n_imem++;
      if (ir_we && irwe_cyc == 0) irwe_cyc = c;
      if (dmem_req) n_dmem++;
      if (dmem_req && dmem_we) n_dwe++;
      if (reg_we) begin n_regwe++; wb_seen = wb_sel; end
      if (c == f + 1) dec_state = state;
      if (c == f + 2) begin aop_seen = alu_op; asa_seen = alu_src_a; asb_seen = alu_src_b; end
      done = pc_we;
      if (pc_we) begin n_pcwe++; pcwe_cyc = c; psel_seen = pc_sel; end
      step();
      if (done) break;
    end
    compared++; if (pcwe_cyc !== total) begin mismatched++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, pcwe_cyc, total); end
    compared++; if (n_pcwe !== 1) begin mismatched++;
      $display("FAIL %s pc_we count: got %0d, expected 1", name, n_pcwe); end
    compared++; if (psel_seen !== e.psel) begin mismatched++;
      $display("FAIL %s pc_sel: got %0d, expected %0d", name, psel_seen, e.psel); end
    compared++; if (n_regwe !== int'(e.writes)) begin mismatched++;
      $display("FAIL %s reg_we count: got %0d, expected %0d", name, n_regwe, e.writes); end
    if (e.writes) begin
      compared++; if (wb_seen !== e.wb) begin mismatched++;
        $display("FAIL %s wb_sel: got %0d, expected %0d", name, wb_seen, e.wb); end
    end
    compared++; if (n_imem !== f || irwe_cyc !== f) begin mismatched++;
      $display("FAIL %s fetch: imem_req %0d cycles ir_we at %0d, expected %0d/%0d", name, n_imem, irwe_cyc, f, f); end
    compared++; if (n_dmem !== (e.memop ? dw + 1 : 0) || n_dwe !== (e.store ? dw + 1 : 0)) begin mismatched++;
      $display("FAIL %s dmem: req %0d we %0d cycles, expected %0d/%0d", name, n_dmem, n_dwe,
               e.memop ? dw + 1 : 0, e.store ? dw + 1 : 0); end
    compared++; if (dec_state !== 3'd1) begin mismatched++;
      $display("FAIL %s decode state: got %0d, expected 1", name, dec_state); end
    compared++; if ({aop_seen, asa_seen, asb_seen} !== {e.aop, e.asa, e.asb}) begin mismatched++;
      $display("FAIL %s execute alu_op/src_a/src_b: got %0d/%0d/%0d, expected %0d/%0d/%0d",
               name, aop_seen, asa_seen, asb_seen, e.aop, e.asa, e.asb); end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = $urandom; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if ({imem_req, ir_we, pc_we, pc_sel, alu_src_a, alu_src_b, alu_op, dmem_req,
           dmem_we, reg_we, wb_sel, illegal_instr, state} !== 20'd0) begin
        mismatched++;
        $display("FAIL reset outputs: imem_req=%0b pc_we=%0b dmem_req=%0b reg_we=%0b state=%0d, expected all 0",
                 imem_req, pc_we, dmem_req, reg_we, state);
      end
      step();
    end
    rst = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    compared++;
    if (imem_req !== 1'b1 || state !== 3'd0) begin mismatched++;
      $display("FAIL reset release: imem_req=%0b state=%0d, expected 1/0", imem_req, state); end
    step();
  endtask

  task automatic test_directed();
    run_instr(32'h00500093, 0, 0, 1'b0, "addi");
    run_instr(32'h0000A103, 0, 2, 1'b0, "lw_wait2");
    run_instr(32'h00208463, 0, 0, 1'b1, "beq_taken");
    run_instr(32'h00208463, 0, 0, 1'b0, "beq_not_taken");
    run_instr(32'h000080E7, 0, 0, 1'b0, "jalr");
    run_instr(32'h0020A023, 1, 1, 1'b0, "sw_waits");
  endtask

  task automatic test_all_opcodes();
    logic [6:0] ops [11];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111, 7'b1110011};
    for (int i = 0; i < 11; i++)
      run_instr({25'($urandom), ops[i]}, $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom % 2), "opcode_sweep");
  endtask

  task automatic test_random();
    logic [6:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 7'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
      while (!is_legal(op)) op = 7'($urandom);
`else
      if (i % 4 != 0) while (!is_legal(op)) op = 7'($urandom);
`endif
      run_instr({25'($urandom), op}, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom % 2), "random");
    end
  endtask

  task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
    instr = 32'h0000007F; branch_taken = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      imem_ready = (c == 1) ? 1'b1 : 1'($urandom % 2);
      dmem_ready = 1'($urandom % 2);
      @(negedge clk);
      if (c >= 3) begin
        compared++;
        if (state !== 3'd5 || illegal_instr !== 1'b1) begin mismatched++;
          $display("FAIL trap cycle %0d: state=%0d illegal=%0b, expected 5/1", c, state, illegal_instr); end
      end
      compared++;
      if (pc_we !== 1'b0 || reg_we !== 1'b0 || imem_req !== (c == 1)) begin mismatched++;
        $display("FAIL trap enables cycle %0d: pc_we=%0b reg_we=%0b imem_req=%0b", c, pc_we, reg_we, imem_req); end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    compared++;
    if (illegal_instr !== 1'b0 || state !== 3'd0 || imem_req !== 1'b1) begin mismatched++;
      $display("FAIL trap cleared by reset: illegal=%0b state=%0d imem_req=%0b, expected 0/0/1",
               illegal_instr, state, imem_req); end
    step();
`else
    run_instr(32'h0000007F, 0, 0, 1'b0, "illegal_nop");
    run_instr(32'h00000071, 1, 0, 1'b1, "illegal_low_bits");
`endif
  endtask

  task automatic test_reset_in_mem();
    instr = 32'h0020A023; branch_taken = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      imem_ready = (c == 1) ? 1'b1 : 1'($urandom % 2);
      dmem_ready = 1'($urandom % 2);
      @(negedge clk);
      if (c == 3) begin
        compared++;
        if (state !== 3'd2) begin mismatched++;
          $display("FAIL sw pre-reset state: got %0d, expected 2", state); end
      end
      step();
    end
    rst = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    compared++;
    if (dmem_req !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0) begin mismatched++;
      $display("FAIL reset in MEM: dmem_req=%0b pc_we=%0b reg_we=%0b, expected 0/0/0", dmem_req, pc_we, reg_we); end
    step();
    rst = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    compared++;
    if (state !== 3'd0 || imem_req !== 1'b1) begin mismatched++;
      $display("FAIL restart after reset: state=%0d imem_req=%0b, expected 0/1", state, imem_req); end
    step();
    run_instr(32'h00500093, 0, 0, 1'b0, "addi_after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_all_opcodes();
    test_illegal();
    test_reset_in_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle control FSM for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the handshakes with instruction and data memory, plus the write enables and mux selects for the PC, IR, ALU, register file and writeback path. It decodes `instr[6:0]`, the same opcode field the immediate generator consumes; immediates reach the ALU via `alu_src_b`.

## Interface
Parameters:
- `RESET_STATE`, default 3'd0 (FETCH): state loaded on reset. Do not change for normal builds.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr`  in  32  IR contents; valid from DECODE onward
- `imem_ready`  in  1  instruction memory has data this cycle
- `dmem_ready`  in  1  data memory completed the access this cycle
- `branch_taken`  in  1  branch comparison result; valid in EXECUTE
- `imem_req`  out  1  instruction fetch request
- `ir_we`  out  1  latch instruction into IR
- `pc_we`  out  1  update PC
- `pc_sel`  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result (JALR; datapath clears bit 0)
- `alu_src_a`  out  1  0 = rs1, 1 = PC
- `alu_src_b`  out  1  0 = rs2, 1 = immediate
- `alu_op`  out  2  0 = add, 1 = branch compare, 2 = funct3/funct7 decode, 3 = pass B
- `dmem_req`  out  1  data access request
- `dmem_we`  out  1  store when 1, load when 0
- `reg_we`  out  1  register file write
- `wb_sel`  out  2  0 = ALU, 1 = load data (datapath latches it on `dmem_ready`), 2 = PC+4
- `illegal_instr`  out  1  sticky illegal-opcode flag
- `state`  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.
- **FETCH**
  - Assert `imem_req`.
  - When `imem_ready` is sampled high: assert `ir_we` that cycle and go to DECODE. Otherwise stay in FETCH.
- **DECODE**
  - One cycle; register file read.
  - Next state is EXECUTE. If the opcode is illegal and the macro is enabled, next state is TRAP.
- **EXECUTE**, by opcode:
  - OP (0110011): `alu_op`=2, `alu_src_b`=0 → WRITEBACK.
  - OP-IMM (0010011): `alu_op`=2, `alu_src_b`=1 → WRITEBACK.
  - LOAD (0000011) / STORE (0100011): `alu_op`=0, `alu_src_b`=1 → MEM.
  - BRANCH (1100011): `alu_op`=1, `pc_we`=1, `pc_sel` = `branch_taken` ? 1 : 0 → FETCH.
  - LUI (0110111): `alu_op`=3, `alu_src_b`=1 → WRITEBACK.
  - AUIPC (0010111): `alu_src_a`=1, `alu_src_b`=1, `alu_op`=0 → WRITEBACK.
  - JAL (1101111) → WRITEBACK.
  - JALR (1100111): `alu_src_b`=1, `alu_op`=0 → WRITEBACK.
  - FENCE (0001111) / SYSTEM (1110011): NOP; `pc_we`=1, `pc_sel`=0 → FETCH.
- **MEM**
  - Hold `dmem_req`=1, with `dmem_we`=1 for stores, until `dmem_ready`.
  - Store, on ready: `pc_we`=1, `pc_sel`=0 → FETCH.
  - Load, on ready → WRITEBACK.
- **WRITEBACK**
  - `reg_we`=1 and `pc_we`=1.
  - `wb_sel`: 1 for load, 2 for JAL/JALR, 0 otherwise.
  - `pc_sel`: 1 for JAL, 2 for JALR, 0 otherwise.
  - Next state is FETCH.
- **TRAP**
  - All enables and requests 0, `illegal_instr`=1.
  - Remain in TRAP until `rst`.
- Outputs are combinational from `state`, `instr[6:0]` and the ready/branch inputs. Only `state` and `illegal_instr` are registered.
- Unused select outputs are 0 in every state.

## Timing
- Reset:
  - `rst` sampled high sets `state`=FETCH and clears `illegal_instr`.
  - While `rst` is high, all outputs are forced to 0, including `imem_req` and `dmem_req`.
  - `imem_req` rises in the first cycle with `rst` low.
- Latency with zero-wait memory:
  - Branch / FENCE / SYSTEM: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR, store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle on `imem_ready` or `dmem_ready` adds 1 cycle.
- Handshake rules:
  - `imem_ready` or `dmem_ready` may be high in the first cycle of the request.
  - A request never drops before its ready is seen, except on reset.
  - Ready inputs are ignored outside FETCH and MEM.
- Reset mid-operation: `rst` in MEM drops `dmem_req` that same cycle. No `reg_we` or `pc_we` is issued, and execution restarts in FETCH.
- `pc_we` and `reg_we` are each asserted for exactly one cycle per instruction.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An opcode outside the eleven listed, or `instr[1:0]`≠2'b11, sends DECODE to TRAP.
  - `illegal_instr` is sticky until reset.
- Not defined:
  - Illegal opcodes are retired as NOP in EXECUTE (`pc_we`=1, `pc_sel`=0 → FETCH).
  - `illegal_instr` is tied to 0 and TRAP is unreachable.

## Test plan
- ADDI x1,x0,5 (0x00500093), zero-wait memory:
  - States FETCH, DECODE, EXECUTE, WRITEBACK.
  - `alu_src_b`=1 and `alu_op`=2 in EXECUTE.
  - `reg_we`=1, `wb_sel`=0, `pc_sel`=0 in cycle 4.
- LW (0x0000A103) with `dmem_ready` low for 2 cycles:
  - `dmem_req`=1 and `dmem_we`=0 for 3 cycles.
  - `reg_we`=1 with `wb_sel`=1 in cycle 7.
- BEQ (0x00208463):
  - `branch_taken`=1: `pc_we`=1 with `pc_sel`=1 in cycle 3.
  - `branch_taken`=0: `pc_sel`=0.
  - `reg_we` stays 0 in both cases.
- JALR (0x000080E7): WRITEBACK shows `wb_sel`=2, `pc_sel`=2, `reg_we`=1.
- Opcode 0x0000007F:
  - With `CTRL_ILLEGAL_TRAP_EN`: `state`=5 and `illegal_instr`=1 from cycle 3, with no `pc_we` or `reg_we`.
  - Without the macro: `pc_we`=1 with `pc_sel`=0 in cycle 3.
- SW (0x0020A023) with `rst` asserted on the first MEM cycle: `dmem_req`=0 that cycle, `state`=0 the next cycle, and `imem_req`=1 once `rst` is low.
